// File: rtl/phase_fifo_spi_scheduler.sv
// phase_fifo_spi_scheduler
//
// Moves phase-detector words one at a time from a non-FWFT FIFO into the SPI
// serializer. Each word goes through the same sequence: one FIFO read, wait
// the fixed read latency, capture, start the serializer, wait for it to
// finish (or time out), then an idle gap before the next read is considered.
//
// Handshake contract: fifo_rd_en is a one-cycle strobe that is only issued
// after IDLE saw the FIFO non-empty, and data is valid exactly RD_LATENCY
// cycles later. spi_go is a one-cycle start pulse; spi_data holds the payload
// from capture until the next capture. The serializer acknowledges by raising
// spi_busy and signals completion by dropping it.
//
// Ports:
//   clk, rst      serial-domain clock, asynchronous active-high reset
//   enable        readout allowed; sampled only while idle
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO read strobe (one-cycle pulse)
//   fifo_data     FIFO read data
//   spi_go        serializer start pulse
//   spi_data      payload held for the serializer
//   spi_busy      serializer transfer in progress
//   word_valid    one-cycle pulse in the cycle a word is captured
//   word_out      last captured word
//   words_sent    completed transfers, wraps
//   timeout_err   sticky busy-timeout flag, cleared only by rst
module phase_fifo_spi_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int RD_LATENCY   = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  spi_go,
  output logic [DATA_WIDTH-1:0] spi_data,
  input  logic                  spi_busy,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic [15:0]           words_sent,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_LOAD      = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  localparam logic [7:0] LAT_LOAD = 8'(RD_LATENCY);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
  localparam logic [7:0] TO_LAST  = 8'(BUSY_TIMEOUT - 1);

  state_t     state, state_nx;
  // Shared counter: latency countdown, busy-wait count up, gap countdown.
  logic [7:0] cnt, cnt_nx;
  logic       capture;
  logic       done_ok;
  logic       timeout_hit;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    capture     = 1'b0;
    done_ok     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        // A foreign transfer (busy already high) also blocks the read.
        if (enable && !fifo_empty && !spi_busy) state_nx = S_READ;
      end
      S_READ: begin
        cnt_nx   = LAT_LOAD;
        state_nx = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        // cnt reaches 1 exactly RD_LATENCY cycles after the read cycle.
        if (cnt <= 8'd1) begin
          capture  = 1'b1;
          state_nx = S_LOAD;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_LOAD: begin
        cnt_nx   = 8'd0;
        state_nx = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (spi_busy) begin
          state_nx = S_WAIT_DONE;
        end else if (cnt >= TO_LAST) begin
          timeout_hit = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_nx = S_IDLE;
          end else begin
            cnt_nx   = GAP_LOAD;
            state_nx = S_GAP;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy) begin
          done_ok = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_nx = S_IDLE;
          end else begin
            cnt_nx   = GAP_LOAD;
            state_nx = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt <= 8'd1) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Strobes decode directly from state so reset clears them asynchronously.
  assign fifo_rd_en = (state == S_READ);
  assign spi_go     = (state == S_LOAD);
  assign word_valid = capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      spi_data    <= '0;
      word_out    <= '0;
      words_sent  <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        spi_data <= fifo_data;
        word_out <= fifo_data;
      end
      if (done_ok)     words_sent  <= words_sent + 16'd1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_fifo_spi_scheduler.sv
// Bench for phase_fifo_spi_scheduler: a FIFO model with fixed read latency,
// a serializer model with configurable busy response, and an event-level
// reference model that predicts every strobe cycle and counter value.
module tb_phase_fifo_spi_scheduler;

  localparam int W   = 16;
  localparam int L   = 2;
  localparam int G   = 4;
  localparam int T   = 8;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data;
  logic          spi_go;
  logic [W-1:0]  spi_data;
  logic          spi_busy;
  logic          word_valid;
  logic [W-1:0]  word_out;
  logic [15:0]   words_sent;
  logic          timeout_err;

  phase_fifo_spi_scheduler #(
    .DATA_WIDTH(W), .RD_LATENCY(L), .GAP_CYCLES(G), .BUSY_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .spi_go(spi_go),
    .spi_data(spi_data), .spi_busy(spi_busy), .word_valid(word_valid),
    .word_out(word_out), .words_sent(words_sent), .timeout_err(timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] fifo_q[$];   // FIFO contents
  logic [W-1:0] exp_q[$];    // words read, expected at spi_go in order
  logic [W-1:0] go_words[$]; // spi_data observed at each spi_go
  int           rd_cyc_q[$];
  int           done_q[$];

  int           data_at = -1;
  logic [W-1:0] data_word = '0;
  int           busy_start = -1, busy_end = -1, to_at = -1;
  int           idle_at = 0, wv_at = -1, go_at = -1;
  bit           prev_cond = 1'b0;
  logic [15:0]  exp_sent = 16'd0;
  logic         exp_to = 1'b0;

  bit           en_req = 1'b0, foreign_req = 1'b0, rst_req = 1'b1;
  int           ser_mode = 0;  // 0 fixed, 1 random, 2 never busy
  int           ser_dly = 2, ser_len = 16;
  int           n_rd = 0, n_go = 0, last_rd = -1, last_wv = -1, last_go = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    idle_at = cyc; prev_cond = 1'b0; data_at = -1;
    busy_start = -1; busy_end = -1; to_at = -1; wv_at = -1; go_at = -1;
    exp_sent = 16'd0; exp_to = 1'b0; exp_q.delete();
  endtask

  task automatic drive();
    bit rst_fall;
    rst_fall = rst && !rst_req;
    if (rst_fall) model_reset();
    rst        = rst_req;
    enable     = en_req;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (cyc == data_at) ? data_word : W'($urandom);
    spi_busy   = foreign_req || (cyc >= busy_start && cyc < busy_end);
  endtask

  task automatic observe();
    int c, dly, len;
    logic [W-1:0] exp_w;
    c = cyc;
    chk("rd_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
    chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, prev_cond});
    if (fifo_rd_en) begin
      n_rd++; last_rd = c; rd_cyc_q.push_back(c);
      if (fifo_q.size() > 0) begin
        data_word = fifo_q.pop_front();
        exp_q.push_back(data_word);
      end
      data_at = c + L; wv_at = c + L; go_at = c + L + 1; idle_at = BIG;
    end
    chk("word_valid", {31'd0, word_valid}, {31'd0, c == wv_at});
    if (word_valid) last_wv = c;
    chk("spi_go", {31'd0, spi_go}, {31'd0, c == go_at});
    if (spi_go) begin
      n_go++; last_go = c; go_words.push_back(spi_data);
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("spi_data", 32'(spi_data), 32'(exp_w));
      chk("word_out", 32'(word_out), 32'(exp_w));
      dly = (ser_mode == 2) ? 1000 : (ser_mode == 1) ? $urandom_range(1, 4) : ser_dly;
      len = (ser_mode == 1) ? $urandom_range(1, 12) : ser_len;
      if (dly > T) begin
        to_at = c + T; idle_at = c + T + G + 1; busy_start = -1; busy_end = -1;
      end else begin
        busy_start = c + dly; busy_end = busy_start + len; idle_at = busy_end + G + 1;
      end
    end
    chk("words_sent", 32'(words_sent), 32'(exp_sent));
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, exp_to});
    if (c == busy_end) begin exp_sent++; done_q.push_back(c); end
    if (c == to_at)    begin exp_to = 1'b1; done_q.push_back(c); end
    prev_cond = (c >= idle_at) && enable && !fifo_empty && !spi_busy;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1; cyc++;
    drive();
    @(negedge clk);
    if (!rst) observe();
  endtask

  task automatic run_quiet(input int max);
    int n;
    n = 0;
    while (n < max && !(idle_at < BIG && cyc > idle_at + 1 &&
                        (fifo_q.size() == 0 || !en_req || foreign_req))) begin
      step(); n++;
    end
    chk("run_bound", {31'd0, n < max}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_rd, base_go, drop_cyc, n;
    rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_data = '0; spi_busy = 1'b0;
    repeat (3) step();
    chk("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_spi_go", {31'd0, spi_go}, 32'd0);
    chk("rst_spi_data", 32'(spi_data), 32'd0);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word_out", 32'(word_out), 32'd0);
    chk("rst_words_sent", 32'(words_sent), 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst_req = 1'b0;
    step();

    // Single word, busy 2 cycles after go for 16 cycles.
    fifo_q.push_back(16'hA5C3); ser_mode = 0; ser_dly = 2; ser_len = 16; en_req = 1'b1;
    run_quiet(200);
    chk("t1_reads", n_rd, 1);
    chk("t1_wv_latency", last_wv - last_rd, L);
    chk("t1_go_latency", last_go - last_rd, L + 1);
    chk("t1_spi_data", 32'(go_words[0]), 32'hA5C3);
    chk("t1_words_sent", 32'(words_sent), 32'd1);

    // Three preloaded words in order, then idle while empty.
    go_words.delete(); rd_cyc_q.delete(); done_q.delete();
    fifo_q.push_back(16'h0001); fifo_q.push_back(16'h0002); fifo_q.push_back(16'h0003);
    ser_dly = 1; ser_len = 3;
    run_quiet(300);
    chk("t2_go_count", go_words.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_word_order", 32'(go_words[i]), i + 1);
    chk("t2_spacing_a", rd_cyc_q[1] - done_q[0], G + 2);
    chk("t2_spacing_b", rd_cyc_q[2] - done_q[1], G + 2);
    chk("t2_words_sent", 32'(words_sent), 32'd4);
    base_rd = n_rd;
    repeat (10) step();
    chk("t2_idle_no_read", n_rd, base_rd);

    // Random words with random serializer response.
    ser_mode = 1;
    for (int i = 0; i < 10; i++) fifo_q.push_back(W'($urandom));
    run_quiet(2000);
    chk("t3_words_sent", 32'(words_sent), 32'd14);
    chk("t3_fifo_drained", fifo_q.size(), 0);

    // Foreign transfer in progress blocks the read until busy drops.
    ser_mode = 0; ser_dly = 2; ser_len = 4; foreign_req = 1'b1;
    base_rd = n_rd;
    fifo_q.push_back(16'h1234);
    repeat (12) step();
    chk("t4_blocked", n_rd, base_rd);
    foreign_req = 1'b0; drop_cyc = cyc + 1;
    run_quiet(200);
    chk("t4_read_after_drop", last_rd, drop_cyc + 1);
    chk("t4_words_sent", 32'(words_sent), 32'd15);

    // Enable dropped while the serializer is busy.
    base_rd = n_rd; ser_len = 10;
    fifo_q.push_back(16'hBEEF); fifo_q.push_back(16'hCAFE);
    n = 0;
    while (!spi_busy && n < 100) begin step(); n++; end
    chk("t5_busy_seen", {31'd0, spi_busy}, 32'd1);
    en_req = 1'b0;
    run_quiet(200);
    repeat (10) step();
    chk("t5_words_sent", 32'(words_sent), 32'd16);
    chk("t5_single_read", n_rd - base_rd, 1);
    chk("t5_word_left", fifo_q.size(), 1);

    // Asynchronous reset during the capture cycle of WAIT_DATA.
    en_req = 1'b1; base_rd = n_rd; n = 0;
    while (n_rd == base_rd && n < 50) begin step(); n++; end
    chk("t6_read_seen", n_rd - base_rd, 1);
    step();
    @(posedge clk); #1; cyc++;
    drive();
    #1;
    chk("t6_in_capture", {31'd0, word_valid}, 32'd1);
    rst_req = 1'b1; rst = 1'b1;
    #1;
    chk("t6_rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("t6_rst_spi_go", {31'd0, spi_go}, 32'd0);
    chk("t6_rst_spi_data", 32'(spi_data), 32'd0);
    chk("t6_rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("t6_rst_word_out", 32'(word_out), 32'd0);
    chk("t6_rst_words_sent", 32'(words_sent), 32'd0);
    chk("t6_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    repeat (2) step();
    base_go = n_go;
    chk("t6_no_go_in_reset", {31'd0, spi_go}, 32'd0);
    rst_req = 1'b0;
    fifo_q.push_back(16'h0F0F);
    go_words.delete(); base_rd = n_rd; ser_len = 4;
    run_quiet(200);
    chk("t6_clean_read", n_rd - base_rd, 1);
    chk("t6_go_count", n_go - base_go, 1);
    chk("t6_word", 32'(go_words[0]), 32'h0F0F);
    chk("t6_words_sent", 32'(words_sent), 32'd1);

    // Serializer never answers: timeout, no count, retry next word.
    ser_mode = 2; base_rd = n_rd;
    fifo_q.push_back(16'h1111); fifo_q.push_back(16'h2222);
    run_quiet(300);
    chk("t7_timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("t7_words_sent", 32'(words_sent), 32'd1);
    chk("t7_retry_reads", n_rd - base_rd, 2);

    // words_sent wrap from 0xFFFF to 0x0000.
    rst_req = 1'b1;
    repeat (2) step();
    rst_req = 1'b0;
    step();
    force dut.words_sent = 16'hFFFE;
    #1;
    release dut.words_sent;
    exp_sent = 16'hFFFE;
    ser_mode = 0; ser_dly = 1; ser_len = 3;
    fifo_q.push_back(16'h7777);
    run_quiet(200);
    chk("t8_words_ffff", 32'(words_sent), 32'hFFFF);
    fifo_q.push_back(16'h8888);
    run_quiet(200);
    chk("t8_words_wrap", 32'(words_sent), 32'h0000);
    chk("t8_no_timeout", {31'd0, timeout_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
